// File: rtl/sm_warp_done_collector_if.sv
// Response handshake between the warp-done collector and its consumer.
// Valid/ready contract: the master raises rsp_valid_o with rsp_wid_o and holds
// both stable until a rising clk edge samples rsp_valid_o && rsp_ready_i high
// (a "fire"). rsp_valid_o never depends combinationally on rsp_ready_i. The
// slave may drive rsp_ready_i at any time, including before valid rises.
interface sm_warp_done_collector_if #(
    parameter int DEPTH_WARP = 5
);
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DEPTH_WARP-1:0] rsp_wid_o;

    modport master (
        output rsp_valid_o,
        output rsp_wid_o,
        input  rsp_ready_i
    );

    modport slave (
        input  rsp_valid_o,
        input  rsp_wid_o,
        output rsp_ready_i
    );
endinterface

// File: rtl/sm_warp_done_collector.sv
// Warp completion collector.
// Per-warp done pulses are latched into a pending vector. A round-robin
// arbiter moves one pending warp at a time into a single output register,
// which drives the response handshake. Pulses on a warp that is already
// pending, and whose bit is not being cleared in the same cycle, set a sticky
// duplicate error and are otherwise absorbed.
// Optional feature: define SM_WARP_DONE_CNT_EN to count accepted responses on
// done_cnt_o (16-bit, wrapping). Without it done_cnt_o is tied to zero.
module sm_warp_done_collector #(
    parameter int NUM_WARP   = 32,
    parameter int DEPTH_WARP = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_WARP-1:0]  warp_done_i,
    sm_warp_done_collector_if.master rsp,
    output logic [NUM_WARP-1:0]  pending_o,
    output logic                 dup_err_o,
    output logic [15:0]          done_cnt_o
);

    logic [NUM_WARP-1:0]   r_pending;
    logic                  r_valid;
    logic [DEPTH_WARP-1:0] r_wid;
    logic [DEPTH_WARP-1:0] r_ptr;
    logic                  r_dup;

    logic                  w_fire;
    logic                  w_any;
    logic                  w_load;
    logic                  w_found;
    logic [DEPTH_WARP-1:0] w_sel;
    logic [DEPTH_WARP-1:0] w_ptr_nxt;
    logic [NUM_WARP-1:0]   w_rot;
    logic [NUM_WARP-1:0]   w_clr;
    logic [NUM_WARP-1:0]   w_dup_hit;
    logic [NUM_WARP-1:0]   w_pending_nxt;
    int                    w_idx;

    assign w_fire = r_valid & rsp.rsp_ready_i;
    assign w_any  = |r_pending;
    // The output slot can take a new warp when it is empty or draining now.
    assign w_load = (!r_valid || w_fire) && w_any;

    // Round-robin pick: rotate pending so r_ptr sits at bit 0, take the lowest set bit.
    always_comb begin
        w_rot   = NUM_WARP'({r_pending, r_pending} >> r_ptr);
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = 0;
        for (int i = 0; i < NUM_WARP; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_idx   = int'(r_ptr) + i;
                if (w_idx >= NUM_WARP) begin
                    w_idx = w_idx - NUM_WARP;
                end
                w_sel = DEPTH_WARP'(w_idx);
            end
        end
    end

    // Pending vector next-state: clear the granted bit, then OR in new pulses so
    // a pulse coinciding with its own clear survives as a fresh completion.
    always_comb begin
        w_clr         = w_load ? (NUM_WARP'(1) << w_sel) : '0;
        w_dup_hit     = warp_done_i & r_pending & ~w_clr;
        w_pending_nxt = (r_pending & ~w_clr) | warp_done_i;
        w_ptr_nxt     = (int'(w_sel) == NUM_WARP - 1) ? '0 : w_sel + 1'b1;
    end

    // Pending latch and sticky duplicate flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_dup     <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            if (|w_dup_hit) begin
                r_dup <= 1'b1;
            end
        end
    end

    // Output register and round-robin pointer; valid drops only on an idle fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_wid   <= '0;
            r_ptr   <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_wid   <= w_sel;
            r_ptr   <= w_ptr_nxt;
        end else if (w_fire) begin
            r_valid <= 1'b0;
        end
    end

`ifdef SM_WARP_DONE_CNT_EN
    logic [15:0] r_cnt;

    // Accepted-response counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 16'h0000;
        end else if (w_fire) begin
            r_cnt <= r_cnt + 16'h0001;
        end
    end

    assign done_cnt_o = r_cnt;
`else
    assign done_cnt_o = 16'h0000;
`endif

    assign rsp.rsp_valid_o = r_valid;
    assign rsp.rsp_wid_o   = r_wid;
    assign pending_o       = r_pending;
    assign dup_err_o       = r_dup;

endmodule
